// File: rtl/ov5640_pkg.sv
// Shared definitions for the OV5640 power-up / register-configuration sequencer:
// state encoding, table tags, SCCB device IDs and ewdata field layout.
`timescale 1ns/1ps
package ov5640_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_PWDN_WAIT = 4'd0;
    localparam state_t ST_RST_WAIT  = 4'd1;
    localparam state_t ST_INIT_WAIT = 4'd2;
    localparam state_t ST_FETCH     = 4'd3;
    localparam state_t ST_ISSUE     = 4'd4;
    localparam state_t ST_WAIT_DONE = 4'd5;
    localparam state_t ST_DELAY     = 4'd6;
    localparam state_t ST_NEXT      = 4'd7;
    localparam state_t ST_DONE      = 4'd8;
    localparam state_t ST_RD_ISSUE  = 4'd9;
    localparam state_t ST_RD_WAIT   = 4'd10;

    localparam int CNT_W = 20;

    localparam logic [15:0] DELAY_TAG     = 16'hFFFF;
    localparam logic [15:0] REG_SYS_CTRL0 = 16'h3008;
    localparam logic [7:0]  SCCB_ID_W     = 8'h78;
    localparam logic [7:0]  SCCB_ID_R     = 8'h79;

    localparam int EW_DEV_LSB = 24;
    localparam int EW_REG_LSB = 8;
    localparam int EW_DAT_LSB = 0;

    function automatic logic [31:0] pack_ewdata(input logic [7:0]  dev,
                                                input logic [15:0] addr,
                                                input logic [7:0]  data);
        logic [31:0] w;
        w = 32'h0000_0000;
        w[EW_DEV_LSB +: 8]  = dev;
        w[EW_REG_LSB +: 16] = addr;
        w[EW_DAT_LSB +: 8]  = data;
        return w;
    endfunction

endpackage

// File: rtl/ov5640_cfg_seq.sv
// OV5640 power-up and register-table sequencer driving an SCCB master.
// Optional build macro CFG_READBACK_EN: read back each written register and flag mismatches on cfg_err.
`timescale 1ns/1ps
module ov5640_cfg_seq
    import ov5640_pkg::*;
#(
    parameter int          PWDN_CYC = 50_000,
    parameter int          RST_CYC  = 50_000,
    parameter int          INIT_CYC = 1_000_000,
    parameter int          MS_CYC   = 50_000,
    parameter int          REG_NUM  = 252,
    parameter int          ADDR_W   = 8,
    parameter logic [7:0]  SCCB_ID  = SCCB_ID_W
) (
    input  logic              clk_sys50m,
    input  logic              rst_n,
    input  logic              cfg_req,
    output logic              ov5640_pwdn,
    output logic              ov5640_rst_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [23:0]       rom_data,
    output logic              estart,
    output logic [31:0]       ewdata,
    input  logic              iic_done,
    input  logic [7:0]        riic_data,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_err
);

`ifdef CFG_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    // PWDN_WAIT loads one cycle late (from the reset value), hence the -2.
    localparam logic [CNT_W-1:0] PWDN_LD  = CNT_W'(PWDN_CYC - 2);
    localparam logic [CNT_W-1:0] RST_LD   = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] INIT_LD  = CNT_W'(INIT_CYC - 1);
    localparam logic [CNT_W-1:0] MS_LD    = CNT_W'(MS_CYC - 1);
    localparam logic [CNT_W-1:0] FETCH_LD = 20'd1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(REG_NUM - 1);

    state_t              state_r, state_nxt;
    logic [CNT_W-1:0]    cnt_r, cnt_nxt, cnt_dec_s;
    logic                cnt_arm_r, arm_nxt;
    logic [7:0]          ms_left_r, ms_nxt;
    logic [ADDR_W-1:0]   rom_addr_r, addr_nxt;
    logic [23:0]         entry_r, entry_nxt;
    logic                err_r, err_nxt;
    logic                pwdn_r, pwdn_nxt;
    logic                sen_rst_n_r, sen_rst_n_nxt;
    logic                estart_r, estart_nxt;
    logic [31:0]         ewdata_r, ewdata_nxt;
    logic                busy_r, busy_nxt;
    logic                done_r, done_nxt;
    logic                rd_mismatch_s;

    assign cnt_dec_s     = (cnt_r != 20'd0) ? (cnt_r - 20'd1) : 20'd0;
    assign rd_mismatch_s = (riic_data != entry_r[7:0]);

    // State, counter and registered outputs.
    always_ff @(posedge clk_sys50m or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_PWDN_WAIT;
            cnt_r       <= 20'd0;
            cnt_arm_r   <= 1'b0;
            ms_left_r   <= 8'd0;
            rom_addr_r  <= {ADDR_W{1'b0}};
            entry_r     <= 24'd0;
            err_r       <= 1'b0;
            pwdn_r      <= 1'b1;
            sen_rst_n_r <= 1'b0;
            estart_r    <= 1'b0;
            ewdata_r    <= 32'd0;
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt;
            cnt_r       <= cnt_nxt;
            cnt_arm_r   <= arm_nxt;
            ms_left_r   <= ms_nxt;
            rom_addr_r  <= addr_nxt;
            entry_r     <= entry_nxt;
            err_r       <= err_nxt;
            pwdn_r      <= pwdn_nxt;
            sen_rst_n_r <= sen_rst_n_nxt;
            estart_r    <= estart_nxt;
            ewdata_r    <= ewdata_nxt;
            busy_r      <= busy_nxt;
            done_r      <= done_nxt;
        end
    end

    // Next-state, shared counter reloads and table walk.
    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_dec_s;
        arm_nxt   = 1'b1;
        ms_nxt    = ms_left_r;
        addr_nxt  = rom_addr_r;
        entry_nxt = entry_r;
        err_nxt   = err_r;
        case (state_r)
            ST_PWDN_WAIT: begin
                if (!cnt_arm_r) begin
                    cnt_nxt = PWDN_LD;
                end else if (cnt_r == 20'd0) begin
                    state_nxt = ST_RST_WAIT;
                    cnt_nxt   = RST_LD;
                end else begin
                    cnt_nxt = cnt_dec_s;
                end
            end
            ST_RST_WAIT: begin
                if (cnt_r == 20'd0) begin
                    state_nxt = ST_INIT_WAIT;
                    cnt_nxt   = INIT_LD;
                end else begin
                    cnt_nxt = cnt_dec_s;
                end
            end
            ST_INIT_WAIT: begin
                if (cnt_r == 20'd0) begin
                    state_nxt = ST_FETCH;
                    cnt_nxt   = FETCH_LD;
                end else begin
                    cnt_nxt = cnt_dec_s;
                end
            end
            ST_FETCH: begin
                // rom_data reflects rom_addr on the second FETCH cycle.
                if (cnt_r == 20'd0) begin
                    entry_nxt = rom_data;
                    if (rom_data[23:8] == DELAY_TAG) begin
                        if (rom_data[7:0] == 8'd0) begin
                            state_nxt = ST_NEXT;
                        end else begin
                            state_nxt = ST_DELAY;
                            cnt_nxt   = MS_LD;
                            ms_nxt    = rom_data[7:0] - 8'd1;
                        end
                    end else begin
                        state_nxt = ST_ISSUE;
                    end
                end else begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (iic_done) begin
                    if (READBACK && (entry_r[23:8] != REG_SYS_CTRL0)) begin
                        state_nxt = ST_RD_ISSUE;
                    end else begin
                        state_nxt = ST_NEXT;
                    end
                end else begin
                    state_nxt = ST_WAIT_DONE;
                end
            end
            ST_RD_ISSUE: begin
                state_nxt = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (iic_done) begin
                    err_nxt   = err_r | (READBACK & rd_mismatch_s);
                    state_nxt = ST_NEXT;
                end else begin
                    state_nxt = ST_RD_WAIT;
                end
            end
            ST_DELAY: begin
                // Counter counts one millisecond; ms_left counts remaining units.
                if (cnt_r == 20'd0) begin
                    if (ms_left_r == 8'd0) begin
                        state_nxt = ST_NEXT;
                    end else begin
                        ms_nxt  = ms_left_r - 8'd1;
                        cnt_nxt = MS_LD;
                    end
                end else begin
                    cnt_nxt = cnt_dec_s;
                end
            end
            ST_NEXT: begin
                if (rom_addr_r == LAST_ADDR) begin
                    state_nxt = ST_DONE;
                end else begin
                    addr_nxt  = rom_addr_r + ADDR_W'(1);
                    state_nxt = ST_FETCH;
                    cnt_nxt   = FETCH_LD;
                end
            end
            ST_DONE: begin
                if (cfg_req) begin
                    addr_nxt  = {ADDR_W{1'b0}};
                    state_nxt = ST_FETCH;
                    cnt_nxt   = FETCH_LD;
                end else begin
                    state_nxt = ST_DONE;
                end
            end
            default: begin
                state_nxt = ST_PWDN_WAIT;
                cnt_nxt   = 20'd0;
                arm_nxt   = 1'b0;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state.
    always_comb begin
        pwdn_nxt      = (state_nxt == ST_PWDN_WAIT);
        sen_rst_n_nxt = !((state_nxt == ST_PWDN_WAIT) || (state_nxt == ST_RST_WAIT));
        estart_nxt    = (state_nxt == ST_ISSUE) || (state_nxt == ST_RD_ISSUE);
        busy_nxt      = (state_nxt != ST_DONE);
        done_nxt      = (state_nxt == ST_DONE);
        if (state_nxt == ST_ISSUE) begin
            ewdata_nxt = pack_ewdata(SCCB_ID, rom_data[23:8], rom_data[7:0]);
        end else if (state_nxt == ST_RD_ISSUE) begin
            ewdata_nxt = pack_ewdata(SCCB_ID | 8'h01, entry_r[23:8], 8'h00);
        end else begin
            ewdata_nxt = ewdata_r;
        end
    end

    assign ov5640_pwdn  = pwdn_r;
    assign ov5640_rst_n = sen_rst_n_r;
    assign rom_addr     = rom_addr_r;
    assign estart       = estart_r;
    assign ewdata       = ewdata_r;
    assign cfg_busy     = busy_r;
    assign cfg_done     = done_r;
    assign cfg_err      = err_r;

endmodule

// File: tb/tb_ov5640_cfg_seq.sv
// Scoreboard bench for ov5640_cfg_seq: a 3-entry table, an SCCB slave model with
// a 5-cycle response, and checks on power timing, SCCB words, replay and reset abort.
`timescale 1ns/1ps
module tb_ov5640_cfg_seq;

    localparam int PWDN_CYC = 10;
    localparam int RST_CYC  = 10;
    localparam int INIT_CYC = 20;
    localparam int MS_CYC   = 5;
    localparam int REG_NUM  = 3;
    localparam int ADDR_W   = 8;
`ifdef CFG_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic              clk_sys50m = 1'b0;
    logic              rst_n      = 1'b0;
    logic              cfg_req    = 1'b0;
    logic              ov5640_pwdn, ov5640_rst_n, estart, cfg_busy, cfg_done, cfg_err;
    logic [ADDR_W-1:0] rom_addr;
    logic [23:0]       rom_data   = 24'd0;
    logic [31:0]       ewdata;
    logic              iic_done;
    logic              slave_done = 1'b0;
    logic              manual_done = 1'b0;
    logic [7:0]        riic_data  = 8'd0;
    logic              hold_done  = 1'b0;
    logic              slv_rd;
    logic [7:0]        slv_last   = 8'd0;
    logic [23:0]       rom [0:3];

    logic [31:0] sb[$];
    int          est_cyc[$];
    int          n_est = 0, cyc = 0, pwdn_fall = -1, rst_rise = -1;
    int          n_tests = 0, n_fail = 0, n0;

    assign iic_done = slave_done | manual_done;

    ov5640_cfg_seq #(
        .PWDN_CYC(PWDN_CYC), .RST_CYC(RST_CYC), .INIT_CYC(INIT_CYC),
        .MS_CYC(MS_CYC), .REG_NUM(REG_NUM), .ADDR_W(ADDR_W), .SCCB_ID(8'h78)
    ) dut (
        .clk_sys50m(clk_sys50m), .rst_n(rst_n), .cfg_req(cfg_req),
        .ov5640_pwdn(ov5640_pwdn), .ov5640_rst_n(ov5640_rst_n),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .estart(estart), .ewdata(ewdata), .iic_done(iic_done), .riic_data(riic_data),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err)
    );

    always #10 clk_sys50m = ~clk_sys50m;

    initial begin
        rom[0] = 24'h3008_82;
        rom[1] = 24'hFFFF_02;
        rom[2] = 24'h3103_11;
        rom[3] = 24'h0000_00;
    end

    always @(posedge clk_sys50m) rom_data <= rom[rom_addr[1:0]];

    always @(posedge clk_sys50m) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: power-pin timing and scoreboard of SCCB words.
    always @(negedge clk_sys50m) begin
        if (!rst_n) begin
            est_cyc.delete();
            pwdn_fall = -1;
            rst_rise  = -1;
        end else begin
            if (!ov5640_pwdn && pwdn_fall < 0) pwdn_fall = cyc;
            if (ov5640_rst_n && rst_rise < 0)  rst_rise  = cyc;
            if (estart) begin
                est_cyc.push_back(cyc);
                n_est++;
                if (sb.size() == 0) check("sb_unexpected_estart", 32'(sb.size()), 32'd1);
                else                check("ewdata", ewdata, sb.pop_front());
            end
        end
    end

    // SCCB slave: answers 5 cycles after estart unless held off.
    initial begin
        forever begin
            @(negedge clk_sys50m);
            if (rst_n && estart && !hold_done) begin
                slv_rd = ewdata[24];
                if (!slv_rd) slv_last = ewdata[7:0];
                repeat (4) @(negedge clk_sys50m);
                if (rst_n) begin
                    riic_data  = (slv_rd && ewdata[23:8] == 16'h3103) ? 8'h00 : slv_last;
                    slave_done = 1'b1;
                    @(negedge clk_sys50m);
                    slave_done = 1'b0;
                end
            end
        end
    end

    task automatic push_table();
        sb.push_back(32'h7830_0882);
        sb.push_back(32'h7831_0311);
        if (RB) sb.push_back(32'h7931_0300);
    endtask

    task automatic pulse_req();
        cfg_req = 1'b1;
        @(negedge clk_sys50m);
        cfg_req = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        for (int i = 0; i < budget && !cfg_done; i++) @(negedge clk_sys50m);
        check(tag, 32'(cfg_done), 32'd1);
    endtask

    task automatic check_reset_values();
        check("rst_pwdn",     32'(ov5640_pwdn),  32'd1);
        check("rst_sen_rstn", 32'(ov5640_rst_n), 32'd0);
        check("rst_estart",   32'(estart),       32'd0);
        check("rst_ewdata",   ewdata,            32'd0);
        check("rst_rom_addr", 32'(rom_addr),     32'd0);
        check("rst_busy",     32'(cfg_busy),     32'd1);
        check("rst_done",     32'(cfg_done),     32'd0);
        check("rst_err",      32'(cfg_err),      32'd0);
    endtask

    task automatic power_up();
        rst_n = 1'b0;
        @(posedge clk_sys50m);
        sb.delete();
        push_table();
        @(negedge clk_sys50m);
        rst_n = 1'b1;
        wait_done(3000, "done_after_power_up");
        check("pwdn_fall_cycle", 32'(pwdn_fall), 32'(PWDN_CYC));
        check("rst_rise_cycle",  32'(rst_rise),  32'(PWDN_CYC + RST_CYC));
        check("first_estart_cycle", (est_cyc.size() > 0) ? 32'(est_cyc[0]) : 32'hFFFF_FFFF,
              32'(PWDN_CYC + RST_CYC + INIT_CYC + 2));
        check("delay_gap", 32'(est_cyc.size() > 1 && (est_cyc[1] - est_cyc[0]) >= 2 * MS_CYC), 32'd1);
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("rom_addr_last", 32'(rom_addr), 32'(REG_NUM - 1));
        check("busy_in_done", 32'(cfg_busy), 32'd0);
        check("cfg_err", 32'(cfg_err), 32'(RB));
    endtask

    initial begin
        repeat (3) @(negedge clk_sys50m);
        check_reset_values();
        power_up();

        // Stray iic_done while in DONE.
        n0 = n_est;
        manual_done = 1'b1;
        @(negedge clk_sys50m);
        manual_done = 1'b0;
        repeat (20) @(negedge clk_sys50m);
        check("stray_done_no_estart", 32'(n_est), 32'(n0));
        check("stray_done_still_done", 32'(cfg_done), 32'd1);
        check("stray_done_addr", 32'(rom_addr), 32'(REG_NUM - 1));

        // Replay with the first iic_done withheld, plus a mid-table cfg_req.
        hold_done = 1'b1;
        push_table();
        n0 = n_est;
        pulse_req();
        for (int i = 0; i < 200 && n_est == n0; i++) @(negedge clk_sys50m);
        repeat (1000) @(negedge clk_sys50m);
        check("withheld_single_estart", 32'(n_est), 32'(n0 + 1));
        check("withheld_addr_stable", 32'(rom_addr), 32'd0);
        check("replay_pwdn", 32'(ov5640_pwdn), 32'd0);
        check("replay_sen_rstn", 32'(ov5640_rst_n), 32'd1);
        pulse_req();
        repeat (5) @(negedge clk_sys50m);
        check("midtable_req_addr", 32'(rom_addr), 32'd0);
        check("midtable_req_busy", 32'(cfg_busy), 32'd1);
        check("midtable_req_no_estart", 32'(n_est), 32'(n0 + 1));
        hold_done = 1'b0;
        manual_done = 1'b1;
        @(negedge clk_sys50m);
        manual_done = 1'b0;
        wait_done(500, "done_after_replay");
        check("replay_sb_drained", 32'(sb.size()), 32'd0);
        check("replay_addr_last", 32'(rom_addr), 32'(REG_NUM - 1));
        check("replay_pwdn_end", 32'(ov5640_pwdn), 32'd0);

        // Reset asserted while waiting on an SCCB transaction.
        hold_done = 1'b1;
        sb.delete();
        push_table();
        n0 = n_est;
        pulse_req();
        for (int i = 0; i < 200 && n_est == n0; i++) @(negedge clk_sys50m);
        repeat (3) @(negedge clk_sys50m);
        check("abort_in_wait_done", 32'(n_est), 32'(n0 + 1));
        rst_n = 1'b0;
        #1;
        check_reset_values();
        hold_done = 1'b0;
        power_up();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
